// File: rtl/branch_trap_compare_arbiter.sv
// Round-robin arbiter sharing one 32-bit not-equal comparator between the branch
// unit (BEQ/BNE) and the trap unit (TEQ/TNE); tagged results return two cycles later.
module branch_trap_compare_arbiter #(
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 branch_request_valid,
  output logic                 branch_request_ready,
  input  logic [31:0]          branch_operand_a,
  input  logic [31:0]          branch_operand_b,
  input  logic                 branch_condition_equal,
  input  logic [TAG_WIDTH-1:0] branch_request_tag,
  input  logic                 trap_request_valid,
  output logic                 trap_request_ready,
  input  logic [31:0]          trap_operand_a,
  input  logic [31:0]          trap_operand_b,
  input  logic                 trap_condition_equal,
  input  logic [TAG_WIDTH-1:0] trap_request_tag,
  input  logic                 pipeline_flush,
  output logic                 branch_response_valid,
  output logic                 branch_response_taken,
  output logic [TAG_WIDTH-1:0] branch_response_tag,
  output logic                 trap_response_valid,
  output logic                 trap_response_taken,
  output logic [TAG_WIDTH-1:0] trap_response_tag,
  output logic                 compare_busy
);

  typedef enum logic {SRC_BRANCH = 1'b0, SRC_TRAP = 1'b1} source_e;

  source_e                last_grant;
  source_e                stage_source;
  logic                   stage_valid;
  logic                   stage_condition_equal;
  logic [31:0]            stage_operand_a;
  logic [31:0]            stage_operand_b;
  logic [TAG_WIDTH-1:0]   stage_tag;

  logic branch_eligible, trap_eligible;
  logic branch_grant, trap_grant;
  logic branch_handshake, trap_handshake;
  logic stage_not_equal, stage_taken;
  logic branch_issue, trap_issue;

  // Handshake: a transfer happens in any cycle where valid & ready are both high.
  // Ready may depend on valid; requesters must never make valid depend on ready.
  always_comb begin
    branch_eligible = branch_request_valid & ~pipeline_flush;
    trap_eligible   = trap_request_valid;
    branch_grant    = 1'b0;
    trap_grant      = 1'b0;
    if (branch_eligible && trap_eligible) begin
      branch_grant = (last_grant == SRC_TRAP);
      trap_grant   = (last_grant == SRC_BRANCH);
    end else begin
      branch_grant = branch_eligible;
      trap_grant   = trap_eligible;
    end
  end

  // Readys are held low while reset is asserted so nothing is accepted.
  assign branch_request_ready = reset_n & branch_grant;
  assign trap_request_ready   = reset_n & trap_grant;

  assign branch_handshake = branch_request_valid & branch_request_ready;
  assign trap_handshake   = trap_request_valid & trap_request_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid           <= 1'b0;
      stage_source          <= SRC_BRANCH;
      stage_condition_equal <= 1'b0;
      stage_operand_a       <= '0;
      stage_operand_b       <= '0;
      stage_tag             <= '0;
      last_grant            <= SRC_TRAP;
    end else begin
      stage_valid <= branch_handshake | trap_handshake;
      if (branch_handshake) begin
        stage_source          <= SRC_BRANCH;
        stage_condition_equal <= branch_condition_equal;
        stage_operand_a       <= branch_operand_a;
        stage_operand_b       <= branch_operand_b;
        stage_tag             <= branch_request_tag;
        last_grant            <= SRC_BRANCH;
      end else if (trap_handshake) begin
        stage_source          <= SRC_TRAP;
        stage_condition_equal <= trap_condition_equal;
        stage_operand_a       <= trap_operand_a;
        stage_operand_b       <= trap_operand_b;
        stage_tag             <= trap_request_tag;
        last_grant            <= SRC_TRAP;
      end
    end
  end

  assign stage_not_equal = |(stage_operand_a ^ stage_operand_b);
  assign stage_taken     = stage_condition_equal ? ~stage_not_equal : stage_not_equal;

  // A flush squashes a branch sitting in the stage; trap entries always complete.
  assign branch_issue = stage_valid & (stage_source == SRC_BRANCH) & ~pipeline_flush;
  assign trap_issue   = stage_valid & (stage_source == SRC_TRAP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      branch_response_valid <= 1'b0;
      branch_response_taken <= 1'b0;
      branch_response_tag   <= '0;
      trap_response_valid   <= 1'b0;
      trap_response_taken   <= 1'b0;
      trap_response_tag     <= '0;
    end else begin
      branch_response_valid <= branch_issue;
      branch_response_taken <= branch_issue & stage_taken;
      branch_response_tag   <= branch_issue ? stage_tag : '0;
      trap_response_valid   <= trap_issue;
      trap_response_taken   <= trap_issue & stage_taken;
      trap_response_tag     <= trap_issue ? stage_tag : '0;
    end
  end

  assign compare_busy = stage_valid;

endmodule

// File: tb/tb_branch_trap_compare_arbiter.sv
// Directed and randomized bench for branch_trap_compare_arbiter with a
// cycle-indexed scoreboard of expected responses.
module tb_branch_trap_compare_arbiter;

  localparam int TW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          branch_request_valid, branch_request_ready;
  logic [31:0]   branch_operand_a, branch_operand_b;
  logic          branch_condition_equal;
  logic [TW-1:0] branch_request_tag;
  logic          trap_request_valid, trap_request_ready;
  logic [31:0]   trap_operand_a, trap_operand_b;
  logic          trap_condition_equal;
  logic [TW-1:0] trap_request_tag;
  logic          pipeline_flush;
  logic          branch_response_valid, branch_response_taken;
  logic [TW-1:0] branch_response_tag;
  logic          trap_response_valid, trap_response_taken;
  logic [TW-1:0] trap_response_tag;
  logic          compare_busy;

  branch_trap_compare_arbiter #(.TAG_WIDTH(TW)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .branch_request_valid  (branch_request_valid),
    .branch_request_ready  (branch_request_ready),
    .branch_operand_a      (branch_operand_a),
    .branch_operand_b      (branch_operand_b),
    .branch_condition_equal(branch_condition_equal),
    .branch_request_tag    (branch_request_tag),
    .trap_request_valid    (trap_request_valid),
    .trap_request_ready    (trap_request_ready),
    .trap_operand_a        (trap_operand_a),
    .trap_operand_b        (trap_operand_b),
    .trap_condition_equal  (trap_condition_equal),
    .trap_request_tag      (trap_request_tag),
    .pipeline_flush        (pipeline_flush),
    .branch_response_valid (branch_response_valid),
    .branch_response_taken (branch_response_taken),
    .branch_response_tag   (branch_response_tag),
    .trap_response_valid   (trap_response_valid),
    .trap_response_taken   (trap_response_taken),
    .trap_response_tag     (trap_response_tag),
    .compare_busy          (compare_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_trap;
    int          due;
    bit          taken;
    logic [TW-1:0] tag;
  } entry_t;

  entry_t exp_q[$];
  int     cyc;
  bit     last_was_trap;
  bit     hs_prev;
  int     checks;
  int     passed;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_was_trap = 1'b1;
    hs_prev       = 1'b0;
  endtask

  // One clock cycle: drive, check, update the reference model, advance.
  task automatic cycle_step(
    input bit bv, input logic [31:0] ba, input logic [31:0] bb, input bit beq, input logic [TW-1:0] btag,
    input bit tv, input logic [31:0] ta, input logic [31:0] tb, input bit teq, input logic [TW-1:0] ttag,
    input bit fl);
    bit be, te, exp_bg, exp_tg;
    bit exp_bv, exp_bt, exp_tvl, exp_tt;
    logic [TW-1:0] exp_btag, exp_ttag;
    entry_t keep[$];
    branch_request_valid   = bv;
    branch_operand_a       = ba;
    branch_operand_b       = bb;
    branch_condition_equal = beq;
    branch_request_tag     = btag;
    trap_request_valid     = tv;
    trap_operand_a         = ta;
    trap_operand_b         = tb;
    trap_condition_equal   = teq;
    trap_request_tag       = ttag;
    pipeline_flush         = fl;
    #1;
    be     = bv && !fl;
    te     = tv;
    exp_bg = be && (!te || last_was_trap);
    exp_tg = te && (!be || !last_was_trap);
    chk("branch_ready", branch_request_ready, exp_bg);
    chk("trap_ready", trap_request_ready, exp_tg);
    chk("dual_ready", branch_request_ready & trap_request_ready, 0);
    chk("compare_busy", compare_busy, hs_prev);
    if (fl) begin
      keep.delete();
      foreach (exp_q[i]) if (exp_q[i].is_trap || exp_q[i].due != cyc + 1) keep.push_back(exp_q[i]);
      exp_q = keep;
    end
    exp_bv = 0; exp_bt = 0; exp_btag = '0;
    exp_tvl = 0; exp_tt = 0; exp_ttag = '0;
    keep.delete();
    foreach (exp_q[i]) begin
      if (exp_q[i].due == cyc) begin
        if (exp_q[i].is_trap) begin exp_tvl = 1; exp_tt = exp_q[i].taken; exp_ttag = exp_q[i].tag; end
        else begin exp_bv = 1; exp_bt = exp_q[i].taken; exp_btag = exp_q[i].tag; end
      end else keep.push_back(exp_q[i]);
    end
    exp_q = keep;
    chk("branch_resp_valid", branch_response_valid, exp_bv);
    chk("trap_resp_valid", trap_response_valid, exp_tvl);
    if (exp_bv) begin
      chk("branch_resp_taken", branch_response_taken, exp_bt);
      chk("branch_resp_tag", branch_response_tag, exp_btag);
    end
    if (exp_tvl) begin
      chk("trap_resp_taken", trap_response_taken, exp_tt);
      chk("trap_resp_tag", trap_response_tag, exp_ttag);
    end
    if (exp_bg) begin
      exp_q.push_back('{is_trap: 0, due: cyc + 2, taken: ((ba == bb) == beq), tag: btag});
      last_was_trap = 0;
    end
    if (exp_tg) begin
      exp_q.push_back('{is_trap: 1, due: cyc + 2, taken: ((ta == tb) == teq), tag: ttag});
      last_was_trap = 1;
    end
    hs_prev = exp_bg || exp_tg;
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle();
    cycle_step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    reset_n              = 1'b0;
    branch_request_valid = 1'b1;
    trap_request_valid   = 1'b1;
    pipeline_flush       = 1'b0;
    #1;
    chk("rst_branch_ready", branch_request_ready, 0);
    chk("rst_trap_ready", trap_request_ready, 0);
    chk("rst_branch_resp_valid", branch_response_valid, 0);
    chk("rst_trap_resp_valid", trap_response_valid, 0);
    chk("rst_busy", compare_busy, 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cyc++;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] ra, rb, one;
    checks = 0;
    passed = 0;
    cyc    = 0;
    model_reset();
    reset_n = 1'b0;
    branch_request_valid = 0; trap_request_valid = 0; pipeline_flush = 0;
    branch_operand_a = 0; branch_operand_b = 0; branch_condition_equal = 0; branch_request_tag = 0;
    trap_operand_a = 0; trap_operand_b = 0; trap_condition_equal = 0; trap_request_tag = 0;
    repeat (2) @(negedge clock);
    branch_request_valid = 1;
    #1;
    chk("reset_branch_ready", branch_request_ready, 0);
    chk("reset_busy", compare_busy, 0);
    chk("reset_branch_resp", {branch_response_valid, branch_response_taken, branch_response_tag}, 0);
    chk("reset_trap_resp", {trap_response_valid, trap_response_taken, trap_response_tag}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // BEQ equal operands, tag 3
    cycle_step(1, 32'h0000_1234, 32'h0000_1234, 1, 4'd3, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    // TNE then TEQ on differing operands
    cycle_step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 4'd9, 0);
    cycle_step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1, 4'd9, 0);
    idle(); idle();
    // Contention for four cycles
    for (int i = 0; i < 4; i++)
      cycle_step(1, i, 5, 0, 4'(i), 1, 7, 7, 1, 4'(8 + i), 0);
    idle(); idle();
    // Branch accepted, then flushed while a trap (and another branch) is offered
    cycle_step(1, 1, 2, 0, 4'd5, 0, 0, 0, 0, 0, 0);
    cycle_step(1, 3, 3, 1, 4'd6, 1, 4, 4, 1, 4'd12, 1);
    idle(); idle(); idle();
    // Reset with entries in flight, then contention grants branch first
    cycle_step(1, 1, 1, 1, 4'd1, 1, 2, 2, 1, 4'd2, 0);
    cycle_step(1, 1, 1, 1, 4'd1, 1, 2, 2, 1, 4'd2, 0);
    pulse_reset();
    idle();
    cycle_step(1, 9, 9, 1, 4'd4, 1, 8, 8, 0, 4'd7, 0);
    cycle_step(1, 9, 9, 1, 4'd4, 1, 8, 8, 0, 4'd7, 0);
    idle(); idle();
    // Single-bit difference sweep, BNE
    for (int k = 0; k < 32; k++) begin
      one = 32'd1;
      cycle_step(1, 32'h0, one << k, 0, 4'(k), 0, 0, 0, 0, 0, 0);
    end
    cycle_step(1, 32'h8000_0000, 32'h8000_0000, 0, 4'd15, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    // Randomized traffic with occasional flushes
    for (int n = 0; n < 400; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? ra : ra ^ (32'd1 << $urandom_range(0, 31));
      cycle_step($urandom_range(0, 1) == 1, ra, rb, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1, rb, ($urandom_range(0, 1) == 1) ? rb : ra,
                 $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0);
    end
    repeat (4) idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d observed=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_trap_compare_arbiter.md
# branch_trap_compare_arbiter

Shares a single 32-bit not-equal comparator between the branch unit (BEQ/BNE) and the trap unit (TEQ/TNE). Each requester presents two operands and a condition sense through a valid/ready handshake. A round-robin arbiter grants one request per cycle into a one-entry operand stage. The block returns a tagged taken/not-taken result to the originating requester. It sits between ID/EX operand selection and the branch-redirect and exception logic.

## Interface
- TAG_WIDTH, 4, width of the per-request tag echoed back with the result
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- branch_request_valid  input  1  branch unit has a comparison pending
- branch_request_ready  output  1  branch request accepted this cycle
- branch_operand_a / branch_operand_b  input  32  operands
- branch_condition_equal  input  1  1 = BEQ (taken if equal), 0 = BNE
- branch_request_tag  input  TAG_WIDTH  branch identifier
- trap_request_valid / trap_request_ready / trap_operand_a / trap_operand_b / trap_condition_equal / trap_request_tag: same as the branch ports, for the trap unit (TEQ/TNE)
- pipeline_flush  input  1  squash all branch work, accepted or offered
- branch_response_valid  output  1  one-cycle pulse; branch result present
- branch_response_taken  output  1  branch condition satisfied
- branch_response_tag  output  TAG_WIDTH  tag of the completed branch
- trap_response_valid / trap_response_taken / trap_response_tag  output  1/1/TAG_WIDTH  same meaning, for traps
- compare_busy  output  1  operand stage holds a live entry

## Operation
- Arbitration (combinational in cycle N):
  - Eligible branch = branch_request_valid & ~pipeline_flush.
  - Eligible trap = trap_request_valid.
  - One eligible requester: that requester is granted.
  - Both eligible: the requester not recorded in last_grant is granted.
  - Only the granted requester's ready is high. The two readys are never both 1.
  - Ready may depend combinationally on valid. Requesters must not make valid depend on ready.
- Handshake and operand stage:
  - A handshake is valid & ready.
  - On handshake, the operand stage captures operands, condition sense, tag, source (branch/trap), and stage_valid=1.
  - With no handshake, stage_valid=0.
  - last_grant updates to the accepting source on every handshake only.
- Compare (cycle N+1):
  - The registered operands drive the internal not-equal comparator (XOR reduction).
  - taken = condition_equal ? ~not_equal : not_equal.
- Response (registered, visible in cycle N+2):
  - Only the source's response_valid pulses for one cycle, carrying taken and tag.
  - The other source's response_valid = 0.
  - Responses have no backpressure. Requesters must sink them.
- Flush:
  - pipeline_flush in cycle N+1 with a branch entry in the operand stage: the entry is dropped and no branch response is issued.
  - Trap entries are never squashed.
  - Flush in cycle N blocks new branch acceptance that cycle.
  - A branch response already registered (visible in N+2) is still presented. The branch unit discards it using its own flush state.
- compare_busy = stage_valid.
- Reset (asynchronous assert, synchronous release to clock):
  - stage_valid=0, last_grant=trap (branch wins first contention).
  - All response valid/taken/tag=0, both readys=0, compare_busy=0.
  - Reset mid-operation discards the in-flight entry. No response follows deassertion.

## Timing
- Latency: handshake in cycle N, response_valid in cycle N+2.
- Throughput: one comparison per cycle, fully pipelined. A new handshake is permitted every cycle regardless of the stage state.
- Back-to-back contention alternates grants: B, T, B, T...
- A single active requester is granted every cycle with no bubbles. last_grant still updates.
- Simultaneous cases:
  - Flush and a branch entry in the stage: flush wins.
  - Flush while a trap is in the stage: the trap completes normally.
  - Flush does not alter last_grant.
- Outputs are glitch-free registers, except the readys (combinational from valids, flush and last_grant).

## Test plan
- Reset release, then branch a=0x0000_1234, b=0x0000_1234, equal=1, tag=3: ready=1 in N; branch_response_valid=1, taken=1, tag=3 in N+2; trap_response_valid=0.
- Trap a=0xFFFF_FFFF, b=0x7FFF_FFFF, equal=0 (TNE), tag=9: trap_response_taken=1 at N+2. Same operands with equal=1: taken=0.
- Both valid continuously for 4 cycles: grants B, T, B, T. Responses alternate with tags preserved. There is never a dual ready.
- Branch accepted in N, pipeline_flush=1 in N+1 while a trap is offered: no branch response at N+2. The trap is accepted in N+1 and responds at N+3. A branch offered during the flush cycle sees ready=0.
- reset_n pulsed low for 1 cycle with entries in flight: all response valids=0 after deassertion. The next contention grants branch first.
- Single-bit difference sweep (a=0, b=1<<k, k=0..31, BNE): every response taken=1. a=b=0x8000_0000: taken=0.
